seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered results and valid/ready handshakes.
// Single-cycle ops are computed and registered on the accepting edge. MUL runs
// an iterative shift-add over WIDTH cycles.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds valid and its payload
// until that edge. valid never depends combinationally on ready. A, B and
// alu_control are sampled only on the input transfer edge. alu_result, zero and
// illegal stay stable while out_valid is high and out_ready is low.
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter needs one extra bit so that it can hold the value WIDTH.
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW:0]     cnt;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;
    logic             is_mul;
    logic             accept;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle result and opcode decode from the presented operands.
    always_comb begin
        shamt      = B[SHW-1:0];
        op_result  = '0;
        op_illegal = 1'b0;
        is_mul     = MUL_EN && (alu_control == 4'b1001);
        case (alu_control)
            4'b0000: op_result = A & B;
            4'b0001: op_result = A << shamt;
            4'b0010: op_result = A + B;
            4'b0011: op_result = A >> shamt;
            4'b0100: op_result = A | B;
            4'b0101: op_result = A ^ B;
            4'b0110: op_result = A - B;
            4'b0111: op_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b1000: op_result = $signed(A) >>> shamt;
            default: op_illegal = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept) state_d = is_mul ? S_MUL : S_DONE;
            S_MUL:   if (cnt == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            alu_result <= '0;
            zero       <= 1'b1;
            illegal    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mcand  <= A;
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            alu_result <= op_result;
                            zero       <= (op_result == '0);
                            illegal    <= op_illegal;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_ONE;
                    // The WIDTH-th iteration writes straight into the result.
                    if (cnt == CNT_LAST) begin
                        alu_result <= acc_next;
                        zero       <= (acc_next == '0);
                        illegal    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: three instances cover WIDTH=32, WIDTH=32 with MUL
// disabled, and WIDTH=8. Each instance has a scoreboard queue that is filled on
// input transfers and checked on output transfers.
module tb_seq_alu;

    localparam logic [3:0] OP_AND = 4'b0000, OP_SLL = 4'b0001, OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011, OP_OR  = 4'b0100, OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Main instance (WIDTH=32, MUL_EN=1).
    logic        m_iv = 0, m_ir, m_ov, m_ordy = 0, m_zr, m_il;
    logic [31:0] m_a = 0, m_b = 0, m_res;
    logic [3:0]  m_op = 0;
    logic [1:0]  m_st;
    // Instance without multiplier.
    logic        n_iv = 0, n_ir, n_ov, n_ordy = 0, n_zr, n_il;
    logic [31:0] n_a = 0, n_b = 0, n_res;
    logic [3:0]  n_op = 0;
    logic [1:0]  n_st;
    // Narrow instance (WIDTH=8).
    logic        e_iv = 0, e_ir, e_ov, e_ordy = 0, e_zr, e_il;
    logic [7:0]  e_a = 0, e_b = 0, e_res;
    logic [3:0]  e_op = 0;
    logic [1:0]  e_st;

    // Expected {illegal, zero, result}.
    logic [33:0] exp_q[$];
    logic [33:0] n_exp_q[$];
    logic [33:0] e_exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .A(m_a), .B(m_b),
        .alu_control(m_op), .out_valid(m_ov), .out_ready(m_ordy), .alu_result(m_res),
        .zero(m_zr), .illegal(m_il), .dbg_state(m_st));

    seq_alu #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(n_iv), .in_ready(n_ir), .A(n_a), .B(n_b),
        .alu_control(n_op), .out_valid(n_ov), .out_ready(n_ordy), .alu_result(n_res),
        .zero(n_zr), .illegal(n_il), .dbg_state(n_st));

    seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .A(e_a), .B(e_b),
        .alu_control(e_op), .out_valid(e_ov), .out_ready(e_ordy), .alu_result(e_res),
        .zero(e_zr), .illegal(e_il), .dbg_state(e_st));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model for width w (<=32); operands are masked to w bits.
    function automatic logic [33:0] model(input logic [31:0] a_in, input logic [31:0] b_in,
                                          input logic [3:0] op_in, input int w, input bit mul_en);
        logic [31:0]        mask, a_w, b_w, r;
        logic signed [31:0] as, bs;
        logic               ill;
        int                 sh;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a_w  = a_in & mask;
        b_w  = b_in & mask;
        as   = $signed(a_w << (32 - w)) >>> (32 - w);
        bs   = $signed(b_w << (32 - w)) >>> (32 - w);
        sh   = int'(b_w % 32'(w));
        r    = 32'd0;
        ill  = 1'b0;
        case (op_in)
            OP_AND: r = a_w & b_w;
            OP_SLL: r = (a_w << sh) & mask;
            OP_ADD: r = (a_w + b_w) & mask;
            OP_SRL: r = a_w >> sh;
            OP_OR:  r = a_w | b_w;
            OP_XOR: r = a_w ^ b_w;
            OP_SUB: r = (a_w - b_w) & mask;
            OP_SLT: r = (as < bs) ? 32'd1 : 32'd0;
            OP_SRA: r = 32'(as >>> sh) & mask;
            OP_MUL: if (mul_en) r = (a_w * b_w) & mask; else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        return {ill, (r == 32'd0), r};
    endfunction

    // Scoreboards: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        logic [33:0] x;
        if (!rst) begin
            if (m_iv && m_ir) exp_q.push_back(model(m_a, m_b, m_op, 32, 1'b1));
            if (m_ov && m_ordy) begin
                check("m_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    check("m_result", 64'(m_res), 64'(x[31:0]));
                    check("m_zero", 64'(m_zr), 64'(x[32]));
                    check("m_illegal", 64'(m_il), 64'(x[33]));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] x;
        if (!rst) begin
            if (n_iv && n_ir) n_exp_q.push_back(model(n_a, n_b, n_op, 32, 1'b0));
            if (n_ov && n_ordy) begin
                check("n_q_nonempty", 64'(n_exp_q.size() != 0), 64'd1);
                if (n_exp_q.size() != 0) begin
                    x = n_exp_q.pop_front();
                    check("n_result", 64'(n_res), 64'(x[31:0]));
                    check("n_zero", 64'(n_zr), 64'(x[32]));
                    check("n_illegal", 64'(n_il), 64'(x[33]));
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [33:0] x;
        if (!rst) begin
            if (e_iv && e_ir) e_exp_q.push_back(model({24'd0, e_a}, {24'd0, e_b}, e_op, 8, 1'b1));
            if (e_ov && e_ordy) begin
                check("e_q_nonempty", 64'(e_exp_q.size() != 0), 64'd1);
                if (e_exp_q.size() != 0) begin
                    x = e_exp_q.pop_front();
                    check("e_result", 64'(e_res), 64'(x[7:0]));
                    check("e_zero", 64'(e_zr), 64'(x[32]));
                    check("e_illegal", 64'(e_il), 64'(x[33]));
                end
            end
        end
    end

    // Drivers. Inputs change #1 after a rising edge. Latency is the number of
    // edges after the accepting edge before out_valid is visible. Operands are
    // scrambled after acceptance.
    task automatic m_issue(input logic [31:0] a_i, input logic [31:0] b_i,
                           input logic [3:0] op_i, input int exp_edges);
        int n;
        m_a = a_i; m_b = b_i; m_op = op_i; m_iv = 1'b1;
        n = 0;
        while (!m_ir && n < 64) begin @(posedge clk); #1; n++; end
        check("m_ready_wait", 64'(m_ir), 64'd1);
        @(posedge clk); #1;
        m_iv = 1'b0; m_a = $urandom; m_b = $urandom; m_op = 4'($urandom_range(0, 15));
        n = 0;
        while (!m_ov && n < 64) begin @(posedge clk); #1; n++; end
        check("m_latency", 64'(n), 64'(exp_edges));
    endtask

    task automatic m_take();
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;
        check("m_ov_cleared", 64'(m_ov), 64'd0);
        check("m_ready_back", 64'(m_ir), 64'd1);
    endtask

    task automatic n_issue(input logic [31:0] a_i, input logic [31:0] b_i, input logic [3:0] op_i);
        int n;
        n_a = a_i; n_b = b_i; n_op = op_i; n_iv = 1'b1;
        @(posedge clk); #1;
        n_iv = 1'b0; n_a = $urandom; n_b = $urandom;
        n = 0;
        while (!n_ov && n < 64) begin @(posedge clk); #1; n++; end
        check("n_latency", 64'(n), 64'd0);
    endtask

    task automatic n_take();
        n_ordy = 1'b1;
        @(posedge clk); #1;
        n_ordy = 1'b0;
        check("n_ov_cleared", 64'(n_ov), 64'd0);
    endtask

    task automatic e_issue(input logic [7:0] a_i, input logic [7:0] b_i,
                           input logic [3:0] op_i, input int exp_edges);
        int n;
        e_a = a_i; e_b = b_i; e_op = op_i; e_iv = 1'b1;
        @(posedge clk); #1;
        e_iv = 1'b0; e_a = 8'($urandom); e_b = 8'($urandom);
        n = 0;
        while (!e_ov && n < 64) begin @(posedge clk); #1; n++; end
        check("e_latency", 64'(n), 64'(exp_edges));
    endtask

    task automatic e_take();
        e_ordy = 1'b1;
        @(posedge clk); #1;
        e_ordy = 1'b0;
        check("e_ov_cleared", 64'(e_ov), 64'd0);
    endtask

    initial begin
        logic [3:0] op_r;
        int         n_acc;
        logic       prev_ir;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(m_ir), 64'd1);
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_result", 64'(m_res), 64'd0);
        check("rst_zero", 64'(m_zr), 64'd1);
        check("rst_illegal", 64'(m_il), 64'd0);
        check("rst_w8_zero", 64'(e_zr), 64'd1);
        rst = 1'b0;

        // ADD, then hold the result with out_ready low.
        m_issue(32'h0000_0005, 32'h0000_0003, OP_ADD, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_result", 64'(m_res), 64'h8);
            check("hold_zero", 64'(m_zr), 64'd0);
            check("hold_in_ready", 64'(m_ir), 64'd0);
            check("hold_out_valid", 64'(m_ov), 64'd1);
        end
        m_take();

        m_issue(32'h1234_5678, 32'h1234_5678, OP_SUB, 0);
        check("sub_zero", 64'(m_zr), 64'd1);
        m_take();
        m_issue(32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 0);
        check("slt_result", 64'(m_res), 64'd1);
        m_take();
        m_issue(32'h8000_0000, 32'h0000_0024, OP_SRA, 0);
        check("sra_result", 64'(m_res), 64'hF800_0000);
        m_take();
        m_issue(32'hDEAD_BEEF, 32'h0000_0000, OP_SLL, 0);
        check("sll0_result", 64'(m_res), 64'hDEAD_BEEF);
        m_take();
        m_issue(32'h0000_0003, 32'h0000_0021, OP_SLL, 0);
        check("sll33_result", 64'(m_res), 64'h6);
        m_take();
        m_issue(32'h0001_0001, 32'h0000_FFFF, OP_MUL, 32);
        check("mul1_result", 64'(m_res), 64'hFFFF_FFFF);
        m_take();
        m_issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 32);
        check("mul2_result", 64'(m_res), 64'h1);
        m_take();
        m_issue(32'h1111_2222, 32'h3333_4444, 4'b1111, 0);
        check("ill_result", 64'(m_res), 64'd0);
        check("ill_zero", 64'(m_zr), 64'd1);
        check("ill_flag", 64'(m_il), 64'd1);
        m_take();

        // Random operations over the whole opcode space.
        for (int i = 0; i < 16; i++) begin
            op_r = 4'($urandom_range(0, 15));
            m_issue($urandom, $urandom, op_r, (op_r == OP_MUL) ? 32 : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            m_take();
        end

        // Reset ten iterations into a multiply.
        m_a = 32'h0000_1234; m_b = 32'h0000_5678; m_op = OP_MUL; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mul_busy_ready", 64'(m_ir), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_out_valid", 64'(m_ov), 64'd0);
        check("abort_in_ready", 64'(m_ir), 64'd1);
        check("abort_result", 64'(m_res), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_result", 64'(m_ov), 64'd0);
        m_issue(32'h0000_0007, 32'h0000_0009, OP_ADD, 0);
        check("post_abort_add", 64'(m_res), 64'h10);
        m_take();

        // MUL_EN=0: MUL is illegal and completes like a single-cycle op.
        n_issue(32'h0000_0003, 32'h0000_0004, OP_MUL);
        check("nomul_result", 64'(n_res), 64'd0);
        check("nomul_illegal", 64'(n_il), 64'd1);
        check("nomul_zero", 64'(n_zr), 64'd1);
        n_take();
        n_issue(32'h0000_0003, 32'h0000_0004, OP_XOR);
        n_take();

        // WIDTH=8.
        e_issue(8'hFF, 8'h01, OP_ADD, 0);
        check("w8_add_zero", 64'(e_zr), 64'd1);
        e_take();
        e_issue(8'h10, 8'h10, OP_MUL, 8);
        check("w8_mul_result", 64'(e_res), 64'd0);
        e_take();
        e_issue(8'h80, 8'h09, OP_SRA, 0);
        check("w8_sra_result", 64'(e_res), 64'hC0);
        e_take();
        for (int i = 0; i < 8; i++) begin
            op_r = 4'($urandom_range(0, 15));
            e_issue(8'($urandom), 8'($urandom), op_r, (op_r == OP_MUL) ? 8 : 0);
            e_take();
        end

        // Back-to-back single-cycle ops with out_ready tied high.
        e_ordy = 1'b1;
        e_iv = 1'b1;
        n_acc = 0;
        prev_ir = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (e_ir) n_acc++;
            if (i > 0) check("w8_b2b_alternate", 64'(e_ir), 64'(!prev_ir));
            prev_ir = e_ir;
            e_a = 8'($urandom); e_b = 8'($urandom); e_op = 4'($urandom_range(0, 8));
            @(posedge clk); #1;
        end
        e_iv = 1'b0;
        check("w8_b2b_accepts", 64'(n_acc), 64'd10);
        @(posedge clk); #1;
        e_ordy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("m_q_drained", 64'(exp_q.size()), 64'd0);
        check("n_q_drained", 64'(n_exp_q.size()), 64'd0);
        check("e_q_drained", 64'(e_exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
